// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates an entry per issued instruction, captures CDB
// results, retires in program order to the register file and raises flush on mispredict.
module reorder_buffer #(
    parameter int SIZE   = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              issue_valid_in,
    input  logic [4:0]        issue_rd_in,
    input  logic              issue_writes_rd_in,
    output logic              ready_out,
    output logic [IDX_W-1:0]  issue_idx_out,
    input  logic              cdb_valid_in,
    input  logic [IDX_W-1:0]  cdb_idx_in,
    input  logic [DATA_W-1:0] cdb_data_in,
    input  logic              cdb_mispredict_in,
    input  logic [31:0]       cdb_target_in,
    input  logic [IDX_W-1:0]  q1_idx_in,
    input  logic [IDX_W-1:0]  q2_idx_in,
    output logic              q1_ready_out,
    output logic              q2_ready_out,
    output logic [DATA_W-1:0] q1_data_out,
    output logic [DATA_W-1:0] q2_data_out,
    output logic              we_out,
    output logic [4:0]        wa_out,
    output logic [DATA_W-1:0] wd_out,
    output logic [IDX_W-1:0]  rob_ix_out,
    output logic              flush_out,
    output logic [SIZE-1:0]   flush_addrs_out,
    output logic [31:0]       redirect_pc_out,
    output logic [IDX_W:0]    count_out
);

    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(SIZE);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE    = (IDX_W+1)'(1);

    logic [IDX_W-1:0]  head_q, tail_q;
    logic [IDX_W:0]    count_q;
    logic [SIZE-1:0]   busy_q, done_q;
    logic [SIZE-1:0]   busy_nx, done_nx;
    logic [SIZE-1:0]   writes_rd_q, mispredict_q;
    logic [4:0]        rd_q     [SIZE];
    logic [DATA_W-1:0] value_q  [SIZE];
    logic [31:0]       target_q [SIZE];

    logic              commit;
    logic              do_flush;
    logic              issue_fire;
    logic              cdb_fire;
    logic [SIZE-1:0]   flush_mask;
    logic [IDX_W-1:0]  head_inc;

    assign ready_out     = (count_q != FULL_COUNT);
    assign issue_idx_out = tail_q;
    assign count_out     = count_q;
    assign head_inc      = head_q + IDX_ONE;

    always_comb begin
        commit     = busy_q[head_q] && done_q[head_q];
        do_flush   = commit && mispredict_q[head_q];
        issue_fire = issue_valid_in && ready_out && !do_flush;
        cdb_fire   = cdb_valid_in && busy_q[cdb_idx_in] && !do_flush;
        flush_mask = busy_q;
        flush_mask[head_q] = 1'b0;
    end

    // A flush wipes every entry; otherwise CDB, retire and allocate touch distinct slots.
    always_comb begin
        busy_nx = busy_q;
        done_nx = done_q;
        if (do_flush) begin
            busy_nx = '0;
            done_nx = '0;
        end else begin
            if (cdb_fire) begin
                done_nx[cdb_idx_in] = 1'b1;
            end
            if (commit) begin
                busy_nx[head_q] = 1'b0;
                done_nx[head_q] = 1'b0;
            end
            if (issue_fire) begin
                busy_nx[tail_q] = 1'b1;
                done_nx[tail_q] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            busy_q <= busy_nx;
            done_q <= done_nx;
            if (do_flush) begin
                head_q  <= head_inc;
                tail_q  <= head_inc;
                count_q <= '0;
            end else begin
                if (commit) begin
                    head_q <= head_inc;
                end
                if (issue_fire) begin
                    tail_q <= tail_q + IDX_ONE;
                end
                case ({issue_fire, commit})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Payload is only ever read behind busy/done, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (issue_fire) begin
            rd_q[tail_q]         <= issue_rd_in;
            writes_rd_q[tail_q]  <= issue_writes_rd_in;
            mispredict_q[tail_q] <= 1'b0;
        end
        if (cdb_fire) begin
            value_q[cdb_idx_in]      <= cdb_data_in;
            mispredict_q[cdb_idx_in] <= cdb_mispredict_in;
            target_q[cdb_idx_in]     <= cdb_target_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            we_out          <= 1'b0;
            wa_out          <= '0;
            wd_out          <= '0;
            rob_ix_out      <= '0;
            flush_out       <= 1'b0;
            flush_addrs_out <= '0;
            redirect_pc_out <= '0;
        end else begin
            if (commit) begin
                we_out     <= writes_rd_q[head_q] && (rd_q[head_q] != 5'd0);
                wa_out     <= rd_q[head_q];
                wd_out     <= value_q[head_q];
                rob_ix_out <= head_q;
            end else begin
                we_out <= 1'b0;
            end
            flush_out       <= do_flush;
            flush_addrs_out <= do_flush ? flush_mask : '0;
            if (do_flush) begin
                redirect_pc_out <= target_q[head_q];
            end
        end
    end

    // Operand forwarding: a live CDB broadcast takes priority over stored results.
    always_comb begin
        q1_ready_out = 1'b0;
        q1_data_out  = '0;
        q2_ready_out = 1'b0;
        q2_data_out  = '0;
        if (cdb_valid_in && (cdb_idx_in == q1_idx_in)) begin
            q1_ready_out = 1'b1;
            q1_data_out  = cdb_data_in;
        end else if (busy_q[q1_idx_in] && done_q[q1_idx_in]) begin
            q1_ready_out = 1'b1;
            q1_data_out  = value_q[q1_idx_in];
        end
        if (cdb_valid_in && (cdb_idx_in == q2_idx_in)) begin
            q2_ready_out = 1'b1;
            q2_data_out  = cdb_data_in;
        end else if (busy_q[q2_idx_in] && done_q[q2_idx_in]) begin
            q2_ready_out = 1'b1;
            q2_data_out  = value_q[q2_idx_in];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: program-order queue model, directed scenarios with literal
// expectations, then randomized traffic with occasional asynchronous resets.
module tb_reorder_buffer;

    localparam int SIZE   = 8;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 32;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              issue_valid_in;
    logic [4:0]        issue_rd_in;
    logic              issue_writes_rd_in;
    logic              ready_out;
    logic [IDX_W-1:0]  issue_idx_out;
    logic              cdb_valid_in;
    logic [IDX_W-1:0]  cdb_idx_in;
    logic [DATA_W-1:0] cdb_data_in;
    logic              cdb_mispredict_in;
    logic [31:0]       cdb_target_in;
    logic [IDX_W-1:0]  q1_idx_in, q2_idx_in;
    logic              q1_ready_out, q2_ready_out;
    logic [DATA_W-1:0] q1_data_out, q2_data_out;
    logic              we_out;
    logic [4:0]        wa_out;
    logic [DATA_W-1:0] wd_out;
    logic [IDX_W-1:0]  rob_ix_out;
    logic              flush_out;
    logic [SIZE-1:0]   flush_addrs_out;
    logic [31:0]       redirect_pc_out;
    logic [IDX_W:0]    count_out;

    reorder_buffer #(.SIZE(SIZE), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
        .issue_writes_rd_in(issue_writes_rd_in), .ready_out(ready_out),
        .issue_idx_out(issue_idx_out), .cdb_valid_in(cdb_valid_in),
        .cdb_idx_in(cdb_idx_in), .cdb_data_in(cdb_data_in),
        .cdb_mispredict_in(cdb_mispredict_in), .cdb_target_in(cdb_target_in),
        .q1_idx_in(q1_idx_in), .q2_idx_in(q2_idx_in),
        .q1_ready_out(q1_ready_out), .q2_ready_out(q2_ready_out),
        .q1_data_out(q1_data_out), .q2_data_out(q2_data_out),
        .we_out(we_out), .wa_out(wa_out), .wd_out(wd_out), .rob_ix_out(rob_ix_out),
        .flush_out(flush_out), .flush_addrs_out(flush_addrs_out),
        .redirect_pc_out(redirect_pc_out), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    // In-flight instructions held oldest first; the front is the next to retire.
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [4:0]        rd;
        logic              wr;
        logic              done;
        logic [DATA_W-1:0] value;
        logic              mp;
        logic [31:0]       target;
    } ent_t;

    ent_t              rob_q[$];
    logic [IDX_W-1:0]  m_tail;
    logic              m_we, m_flush;
    logic [4:0]        m_wa;
    logic [DATA_W-1:0] m_wd;
    logic [IDX_W-1:0]  m_rob;
    logic [SIZE-1:0]   m_mask;
    logic [31:0]       m_redir;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rob_q.delete();
        m_tail = '0; m_we = 0; m_flush = 0; m_wa = '0; m_wd = '0;
        m_rob = '0; m_mask = '0; m_redir = '0;
    endtask

    task automatic model_fwd(input logic [IDX_W-1:0] idx, output logic rdy, output logic [DATA_W-1:0] data);
        rdy = 0;
        data = '0;
        if (cdb_valid_in && cdb_idx_in == idx) begin
            rdy = 1;
            data = cdb_data_in;
        end else begin
            foreach (rob_q[i]) if (rob_q[i].idx == idx && rob_q[i].done) begin
                rdy = 1;
                data = rob_q[i].value;
            end
        end
    endtask

    // One clock edge of the reorder buffer as seen from its interface.
    task automatic model_step();
        int n = rob_q.size();
        bit full = (n == SIZE);
        bit commit = (n > 0) && rob_q[0].done;
        bit flush = commit && rob_q[0].mp;
        ent_t e;
        m_flush = 0;
        m_mask = '0;
        if (commit) begin
            m_we = rob_q[0].wr && (rob_q[0].rd != 0);
            m_wa = rob_q[0].rd;
            m_wd = rob_q[0].value;
            m_rob = rob_q[0].idx;
        end else begin
            m_we = 0;
        end
        if (flush) begin
            m_flush = 1;
            for (int i = 1; i < n; i++) m_mask[rob_q[i].idx] = 1'b1;
            m_redir = rob_q[0].target;
            m_tail = rob_q[0].idx + 1;
            rob_q.delete();
        end else begin
            if (cdb_valid_in) begin
                foreach (rob_q[i]) if (rob_q[i].idx == cdb_idx_in) begin
                    rob_q[i].done = 1;
                    rob_q[i].value = cdb_data_in;
                    rob_q[i].mp = cdb_mispredict_in;
                    rob_q[i].target = cdb_target_in;
                end
            end
            if (commit) void'(rob_q.pop_front());
            if (issue_valid_in && !full) begin
                e = '0;
                e.idx = m_tail;
                e.rd = issue_rd_in;
                e.wr = issue_writes_rd_in;
                rob_q.push_back(e);
                m_tail = m_tail + 1;
            end
        end
    endtask

    task automatic check_comb();
        logic r;
        logic [DATA_W-1:0] d;
        check("ready", ready_out, rob_q.size() != SIZE);
        check("issue_idx", issue_idx_out, m_tail);
        check("count_c", count_out, rob_q.size());
        model_fwd(q1_idx_in, r, d);
        check("q1_ready", q1_ready_out, r);
        if (r) check("q1_data", q1_data_out, d);
        model_fwd(q2_idx_in, r, d);
        check("q2_ready", q2_ready_out, r);
        if (r) check("q2_data", q2_data_out, d);
    endtask

    task automatic check_reg();
        check("we", we_out, m_we);
        check("wa", wa_out, m_wa);
        check("wd", wd_out, m_wd);
        check("rob_ix", rob_ix_out, m_rob);
        check("flush", flush_out, m_flush);
        check("flush_addrs", flush_addrs_out, m_mask);
        check("redirect_pc", redirect_pc_out, m_redir);
        check("count", count_out, rob_q.size());
    endtask

    task automatic cycle();
        #1 check_comb();
        @(posedge clk_in);
        model_step();
        #1 check_reg();
    endtask

    task automatic idle_inputs();
        issue_valid_in = 0; issue_rd_in = '0; issue_writes_rd_in = 0;
        cdb_valid_in = 0; cdb_idx_in = '0; cdb_data_in = '0;
        cdb_mispredict_in = 0; cdb_target_in = '0;
        q1_idx_in = '0; q2_idx_in = '0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic wr);
        @(negedge clk_in);
        idle_inputs();
        issue_valid_in = 1; issue_rd_in = rd; issue_writes_rd_in = wr;
        cycle();
    endtask

    task automatic do_cdb(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data,
                          input logic mp, input logic [31:0] tgt);
        @(negedge clk_in);
        idle_inputs();
        cdb_valid_in = 1; cdb_idx_in = idx; cdb_data_in = data;
        cdb_mispredict_in = mp; cdb_target_in = tgt;
        cycle();
    endtask

    task automatic do_idle();
        @(negedge clk_in);
        idle_inputs();
        cycle();
    endtask

    task automatic sync_reset();
        @(negedge clk_in);
        idle_inputs();
        rst_in = 1;
        model_reset();
        @(negedge clk_in);
        rst_in = 0;
    endtask

    initial begin
        idle_inputs();
        rst_in = 1;
        model_reset();
        #12;
        check("rst_count", count_out, 0);
        check("rst_ready", ready_out, 1);
        check("rst_we", we_out, 0);
        check("rst_flush", flush_out, 0);
        check("rst_idx", issue_idx_out, 0);
        @(negedge clk_in);
        rst_in = 0;

        // Fill to capacity, then one more issue that must be ignored.
        for (int i = 0; i < SIZE; i++) begin
            @(negedge clk_in);
            idle_inputs();
            issue_valid_in = 1; issue_rd_in = 5'(i + 1); issue_writes_rd_in = 1;
            #1 check("fill_idx", issue_idx_out, i);
            cycle();
        end
        check("full_count", count_out, 8);
        check("full_ready", ready_out, 0);
        do_issue(5'd9, 1);
        check("full_tail", issue_idx_out, 0);
        check("full_count2", count_out, 8);

        // Out-of-order completion retires in program order.
        sync_reset();
        do_issue(5'd5, 1);
        do_issue(5'd6, 1);
        do_issue(5'd7, 1);
        do_cdb(3'd2, 30, 0, 0);
        do_cdb(3'd1, 20, 0, 0);
        do_cdb(3'd0, 10, 0, 0);
        check("ooo_we0", we_out, 0);
        do_idle();
        check("ooo_we1", we_out, 1); check("ooo_wa1", wa_out, 5);
        check("ooo_wd1", wd_out, 10); check("ooo_ix1", rob_ix_out, 0);
        do_idle();
        check("ooo_we2", we_out, 1); check("ooo_wa2", wa_out, 6);
        check("ooo_wd2", wd_out, 20); check("ooo_ix2", rob_ix_out, 1);
        do_idle();
        check("ooo_we3", we_out, 1); check("ooo_wa3", wa_out, 7);
        check("ooo_wd3", wd_out, 30); check("ooo_ix3", rob_ix_out, 2);
        do_idle();
        check("ooo_we4", we_out, 0); check("ooo_count", count_out, 0);

        // x0 destination and store-like entries never write the register file.
        do_issue(5'd0, 1);
        do_issue(5'd3, 0);
        do_cdb(3'd3, 32'h11, 0, 0);
        do_cdb(3'd4, 32'h22, 0, 0);
        check("x0_we", we_out, 0);
        do_idle();
        check("st_we", we_out, 0);
        do_idle();
        check("sup_count", count_out, 0);
        check("sup_tail", issue_idx_out, 5);

        // Mispredicted branch at the head squashes the younger entries.
        sync_reset();
        do_issue(5'd1, 1);
        do_issue(5'd2, 1);
        do_issue(5'd3, 1);
        do_issue(5'd4, 1);
        do_cdb(3'd2, 32'h2, 0, 0);
        do_cdb(3'd0, 32'h44, 1, 32'h100);
        do_idle();
        check("mp_we", we_out, 1); check("mp_wa", wa_out, 1);
        check("mp_flush", flush_out, 1);
        check("mp_mask", flush_addrs_out, 8'b0000_1110);
        check("mp_pc", redirect_pc_out, 32'h100);
        check("mp_count", count_out, 0);
        check("mp_tail", issue_idx_out, 1);
        do_idle();
        check("mp_flush_end", flush_out, 0);
        check("mp_mask_end", flush_addrs_out, 0);

        // Forwarding from a stored result and from a live CDB broadcast.
        sync_reset();
        for (int i = 0; i < 5; i++) do_issue(5'(10 + i), 1);
        do_cdb(3'd3, 32'hAB, 0, 0);
        @(negedge clk_in);
        idle_inputs();
        q1_idx_in = 3'd3; q2_idx_in = 3'd4;
        cdb_valid_in = 1; cdb_idx_in = 3'd4; cdb_data_in = 32'h55;
        #1;
        check("fwd_q1_rdy", q1_ready_out, 1); check("fwd_q1_data", q1_data_out, 32'hAB);
        check("fwd_q2_rdy", q2_ready_out, 1); check("fwd_q2_data", q2_data_out, 32'h55);
        cycle();

        // Asynchronous reset with five entries in flight, no clock edge needed.
        #2 rst_in = 1;
        #1;
        check("arst_count", count_out, 0); check("arst_ready", ready_out, 1);
        check("arst_we", we_out, 0); check("arst_flush", flush_out, 0);
        model_reset();
        @(negedge clk_in);
        idle_inputs();
        rst_in = 0;
        issue_valid_in = 1; issue_rd_in = 5'd9; issue_writes_rd_in = 1;
        #1 check("arst_idx", issue_idx_out, 0);
        cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                @(negedge clk_in);
                idle_inputs();
                rst_in = 1;
                model_reset();
                #1 check_reg();
                check_comb();
                @(negedge clk_in);
                rst_in = 0;
            end
            @(negedge clk_in);
            idle_inputs();
            issue_valid_in = ($urandom_range(0, 1) == 1);
            issue_rd_in = 5'($urandom_range(0, 31));
            issue_writes_rd_in = ($urandom_range(0, 3) != 0);
            cdb_valid_in = ($urandom_range(0, 9) < 6);
            if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
                cdb_idx_in = rob_q[$urandom_range(0, rob_q.size() - 1)].idx;
            else
                cdb_idx_in = 3'($urandom_range(0, SIZE - 1));
            cdb_data_in = $urandom;
            cdb_mispredict_in = ($urandom_range(0, 15) == 0);
            cdb_target_in = $urandom;
            q1_idx_in = 3'($urandom_range(0, SIZE - 1));
            q2_idx_in = 3'($urandom_range(0, SIZE - 1));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
